// File: rtl/rx_buffer.sv
// UART receive buffer: two-state capture FSM feeding a first-word fall-through FIFO
// with sticky overflow. Define RX_BUFFER_DROP_ERR_EN to discard errored bytes instead of storing them.
module rx_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_strobe,
  input  logic                     rx_error,
  input  logic                     rd_en,
  input  logic                     clr_overflow,
  output logic [7:0]               rd_data,
  output logic                     rd_err,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int DATA_W = 8;
  localparam int AW     = $clog2(DEPTH);
`ifdef RX_BUFFER_DROP_ERR_EN
  localparam int ENT_W  = DATA_W;
`else
  localparam int ENT_W  = DATA_W + 1;
`endif

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_load;
  logic              w_commit_req;
  logic              w_strobe_lost;

  logic [DATA_W-1:0] r_hold;
  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              r_overflow;

  logic              w_empty;
  logic              w_full;
  logic              w_keep;
  logic              w_pop;
  logic              w_wr;
  logic              w_full_drop;
  logic              w_ovf_set;
  logic [ENT_W-1:0]  w_entry;
  logic [ENT_W-1:0]  w_head;

  // ---- capture FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_commit_req  = 1'b0;
    w_strobe_lost = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_strobe) begin
          w_load      = 1'b1;
          w_state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        // The error flag arrives one cycle behind the byte, so commit happens here.
        w_commit_req  = 1'b1;
        w_strobe_lost = rx_strobe;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Holding register carries no reset; its contents only matter in PEND.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_hold <= rx_data;
    end
  end

  // ---- FIFO write/pop decision ----
`ifdef RX_BUFFER_DROP_ERR_EN
  assign w_keep  = ~rx_error;
  assign w_entry = r_hold;
`else
  assign w_keep  = 1'b1;
  assign w_entry = {rx_error, r_hold};
`endif

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_MAX);
  assign w_pop       = rd_en & ~w_empty;
  assign w_wr        = w_commit_req & w_keep & (~w_full | w_pop);
  assign w_full_drop = w_commit_req & w_keep & w_full & ~w_pop;
  assign w_ovf_set   = w_full_drop | w_strobe_lost;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  // ---- pointers, occupancy, sticky overflow ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // ---- outputs ----
  assign w_head   = r_mem[r_rptr];
  assign rd_data  = w_head[DATA_W-1:0];
`ifdef RX_BUFFER_DROP_ERR_EN
  assign rd_err   = 1'b0;
`else
  assign rd_err   = w_head[DATA_W];
`endif
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: doc/rx_buffer.md
RX_BUFFER -- requirements
Module: rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count; power of 2, minimum 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-005 SHALL have port rx_strobe  input  1  one-cycle pulse; rx_data valid this cycle.
REQ-006 SHALL have port rx_error  input  1  stop/parity error flag, valid the cycle after rx_strobe.
REQ-007 SHALL have port rd_en  input  1  pop request from the consumer.
REQ-008 SHALL have port rd_data  output  8  head-entry byte (first-word fall-through).
REQ-009 SHALL have port rd_err  output  1  head-entry error flag.
REQ-010 SHALL have port empty  output  1  high when the FIFO holds 0 entries.
REQ-011 SHALL have port full  output  1  high when the FIFO holds DEPTH entries.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  number of stored entries.
REQ-013 SHALL have port overflow  output  1  sticky flag: an entry was lost.
REQ-014 SHALL have port clr_overflow  input  1  synchronous clear of overflow.

Function
REQ-015 SHALL implement a two-state capture FSM with states IDLE and PEND.
REQ-016 In IDLE with rx_strobe=1, SHALL latch rx_data into a holding register and go to PEND.
REQ-017 In PEND, SHALL sample rx_error, commit {holding byte, rx_error} to the FIFO, and return to IDLE unconditionally.
REQ-018 SHALL make a committed entry visible (empty=0, rd_data valid) on the cycle after PEND; strobe-to-visible latency is 2 cycles.
REQ-019 SHALL ignore rx_strobe during PEND, drop that byte, and set overflow.
REQ-020 SHALL drive rd_data/rd_err from the head entry whenever empty=0; when empty=1 their values are don't-care.
REQ-021 rd_en with empty=0 SHALL pop one entry at the next edge; rd_en with empty=1 SHALL be ignored and SHALL NOT change any state.
REQ-022 A commit while full with no concurrent valid pop SHALL discard the new entry, set overflow, and leave the stored contents unchanged.
REQ-023 A commit and a valid pop in the same cycle SHALL both take effect and leave count unchanged, including when full.
REQ-024 A commit while empty with rd_en=1 SHALL store the entry; rd_en has no effect that cycle.
REQ-025 SHALL wrap read/write pointers modulo DEPTH; count SHALL range 0..DEPTH, with full=(count==DEPTH) and empty=(count==0).
REQ-026 overflow SHALL stay set until clr_overflow=1; if set and clear occur in the same cycle, set SHALL win.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, pointers=0, count=0, empty=1, full=0, and overflow=0.
REQ-028 Reset asserted during PEND SHALL abandon the pending byte with no commit.
REQ-029 SHALL NOT reset FIFO storage or the holding register; rd_data/rd_err after reset are don't-care.

Configuration
REQ-030 With macro RX_BUFFER_DROP_ERR_EN defined, a PEND commit with rx_error=1 SHALL be discarded without setting overflow, and rd_err SHALL be tied to 0.
REQ-031 Without RX_BUFFER_DROP_ERR_EN, errored bytes SHALL be stored with rd_err=1.

Verification
REQ-032 SHALL cover: strobe 0x41 with error=0 the next cycle -> empty falls 2 cycles after strobe; rd_data=0x41, rd_err=0; after rd_en, empty=1.
REQ-033 SHALL cover: 17 strobes (0x00..0x10) with DEPTH=16 and no reads -> full=1, count=16, overflow=1; reads return 0x00..0x0F in order.
REQ-034 SHALL cover: FIFO full plus commit of 0x55 with rd_en=1 in the same cycle -> count stays 16; last read yields 0x55; overflow stays 0.
REQ-035 SHALL cover: strobe 0xA5 with rx_error=1 the next cycle -> without the macro, rd_data=0xA5 and rd_err=1; with RX_BUFFER_DROP_ERR_EN, empty stays 1.
REQ-036 SHALL cover: strobes on two consecutive cycles (0x11, 0x22) -> only 0x11 stored and overflow=1; clr_overflow pulse -> overflow=0.
REQ-037 SHALL cover: rst asserted mid-PEND after strobe 0x77 -> empty=1 and count=0 immediately, and no entry appears after rst deasserts.
